// File: rtl/thermometer_serializer16.sv
// thermometer_serializer16
// Expands an accepted ones count (0..N) into an N-beat serial stream (count
// ones, then zeros) and presents the matching N-bit thermometer word in
// parallel. Counts above N are clamped to N, and err pulses for one cycle.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  count handshake (in_ready is combinational)
//   in_count           ones count to expand, CW bits
//   out_valid/out_ready serial beat handshake
//   out_bit, out_last  current beat and last-beat flag (registered)
//   out_word           thermometer word of the last accepted count (registered)
//   err                one-cycle pulse after accepting a clamped count
module thermometer_serializer16 #(
  parameter int unsigned N  = 16,
  parameter int unsigned CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_count,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic          out_last,
  output logic [N-1:0]  out_word,
  output logic          err
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] k, k_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0]  word_n;
  logic          err_n;
  logic          out_valid_n, out_bit_n, out_last_n;

  logic          accept;
  logic          over;
  logic [CW-1:0] clamp_cnt;
  logic [N-1:0]  therm;

  // Ready in IDLE, or on the consumed last beat so streams can run back-to-back
  assign in_ready = !rst && ((state == IDLE) ||
                             ((state == SHIFT) && out_last && out_ready));
  assign accept   = in_valid && in_ready;

  // Clamp the incoming count and build its thermometer word
  assign over      = (in_count > CW'(N));
  assign clamp_cnt = over ? CW'(N) : in_count;

  always_comb begin
    therm = '0;
    for (int i = 0; i < int'(N); i++) begin
      therm[i] = (CW'(i) < clamp_cnt);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    k_n     = k;
    cnt_n   = cnt;
    word_n  = out_word;
    err_n   = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT;
          k_n     = '0;
          cnt_n   = clamp_cnt;
          word_n  = therm;
          err_n   = over;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          if (out_last) begin
            if (accept) begin
              k_n    = '0;
              cnt_n  = clamp_cnt;
              word_n = therm;
              err_n  = over;
            end else begin
              state_n = IDLE;
              k_n     = '0;
            end
          end else begin
            k_n = k + CW'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        k_n     = '0;
      end
    endcase

    // Beat outputs are derived from next-state values so bit and last share one register stage
    out_valid_n = (state_n == SHIFT);
    out_bit_n   = (state_n == SHIFT) && (k_n < cnt_n);
    out_last_n  = (state_n == SHIFT) && (k_n == CW'(N - 1));
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      cnt       <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      cnt       <= cnt_n;
      out_word  <= word_n;
      out_valid <= out_valid_n;
      out_bit   <= out_bit_n;
      out_last  <= out_last_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_thermometer_serializer16.sv
// Self-checking bench for thermometer_serializer16: table-driven single
// streams plus hand-written back-to-back and mid-stream reset sequences.
module tb_thermometer_serializer16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_count;
  logic        out_valid;
  logic        out_ready;
  logic        out_bit;
  logic        out_last;
  logic [15:0] out_word;
  logic        err;

  int checks   = 0;
  int failures = 0;

  thermometer_serializer16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .out_word  (out_word),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  count;
    logic [15:0] word;   // expected thermometer word == expected stream (bit k = beat k)
    logic        err;
    int          mode;   // 0: out_ready always 1, 1: out_ready pattern 1,0,0,...
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first beat cycle
  task automatic send(input logic [4:0] c, input logic [15:0] exp_word, input logic exp_err);
    in_valid = 1'b1;
    in_count = c;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("out_valid_first", 32'(out_valid), 32'd1);
    check("err_pulse", 32'(err), 32'(exp_err));
    check("out_word", 32'(out_word), 32'(exp_word));
  endtask

  // Collects 16 beats starting at the current negedge; returns at the negedge after the last beat
  task automatic collect(input int mode, output logic [15:0] bits, output logic [15:0] lasts);
    int   nbeats = 0;
    int   cyc    = 0;
    logic stalled = 1'b0;
    logic pb = 1'b0;
    logic pl = 1'b0;
    bits  = '0;
    lasts = '0;
    while (nbeats < 16 && cyc < 200) begin
      out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      check("stream_valid", 32'(out_valid), 32'd1);
      if (cyc > 0) check("err_low", 32'(err), 32'd0);
      if (stalled) begin
        check("hold_bit", 32'(out_bit), 32'(pb));
        check("hold_last", 32'(out_last), 32'(pl));
      end
      if (out_valid && out_ready) begin
        bits[nbeats]  = out_bit;
        lasts[nbeats] = out_last;
        nbeats++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pb = out_bit;
        pl = out_last;
      end
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("beat_count", 32'(nbeats), 32'd16);
  endtask

  initial begin
    logic [15:0] bits, lasts;
    logic [31:0] stream32;

    vecs[0] = '{count: 5'd5,  word: 16'h001F, err: 1'b0, mode: 0};
    vecs[1] = '{count: 5'd0,  word: 16'h0000, err: 1'b0, mode: 0};
    vecs[2] = '{count: 5'd16, word: 16'hFFFF, err: 1'b0, mode: 0};
    vecs[3] = '{count: 5'd23, word: 16'hFFFF, err: 1'b1, mode: 0};
    vecs[4] = '{count: 5'd9,  word: 16'h01FF, err: 1'b0, mode: 1};
    vecs[5] = '{count: 5'd1,  word: 16'h0001, err: 1'b0, mode: 0};
    vecs[6] = '{count: 5'd31, word: 16'hFFFF, err: 1'b1, mode: 1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_count  = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_word", 32'(out_word), 32'd0);
    check("rst_out_bit", 32'(out_bit), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single streams
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].count, vecs[i].word, vecs[i].err);
      collect(vecs[i].mode, bits, lasts);
      check("stream_bits", 32'(bits), 32'(vecs[i].word));
      check("last_mask", 32'(lasts), 32'h8000);
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("word_held", 32'(out_word), 32'(vecs[i].word));
      check("idle_err", 32'(err), 32'd0);
    end

    // Back-to-back: count 3 then 12 with in_valid held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_count  = 5'd3;
    check("b2b_ready0", 32'(in_ready), 32'd1);
    stream32 = '0;
    for (int b = 0; b < 32; b++) begin
      @(negedge clk);
      if (b == 0) in_count = 5'd12;
      if (b == 16) in_valid = 1'b0;
      check("b2b_valid", 32'(out_valid), 32'd1);
      check("b2b_in_ready", 32'(in_ready), 32'((b == 15) || (b == 31)));
      check("b2b_word", 32'(out_word), (b < 16) ? 32'h0007 : 32'h0FFF);
      check("b2b_last", 32'(out_last), 32'((b == 15) || (b == 31)));
      stream32[b] = out_bit;
    end
    check("b2b_stream", stream32, 32'h0FFF_0007);
    @(negedge clk);
    check("b2b_idle_valid", 32'(out_valid), 32'd0);

    // Reset mid-stream at beat 7 of count 10
    send(5'd10, 16'h03FF, 1'b0);
    repeat (7) @(negedge clk);
    check("pre_rst_bit", 32'(out_bit), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_bit", 32'(out_bit), 32'd0);
    check("mid_rst_word", 32'(out_word), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    send(5'd2, 16'h0003, 1'b0);
    collect(0, bits, lasts);
    check("post_rst_bits", 32'(bits), 32'h0003);
    check("post_rst_last", 32'(lasts), 32'h8000);
    check("post_rst_idle", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/thermometer_serializer16.md
# thermometer_serializer16

Serial unary expander: the decoding counterpart of the 16-input ones-counter. It accepts a 5-bit population count (0..16) over a valid/ready handshake. It then replays the count as a 16-beat serial bitstream: `count` ones first, then zeros. It also presents the equivalent 16-bit thermometer word in parallel. It sits between count-producing logic and any consumer that needs the unary or thermometer form back, for example bit-serial stimulus for counter checks.

## Interface
- `N`, 16, stream length in beats and thermometer width.
- `CW`, 5, count width; `CW` = ceil(log2(`N`+1)).
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  `in_count` is valid.
- `in_ready`  output  1  block can accept a count this cycle.
- `in_count`  input  `CW`  ones count to expand; legal range 0..`N`.
- `out_valid`  output  1  `out_bit` carries a beat.
- `out_ready`  input  1  consumer takes the beat this cycle.
- `out_bit`  output  1  current serial beat.
- `out_last`  output  1  current beat is beat `N`-1.
- `out_word`  output  `N`  thermometer word of the accepted count; bit i = (i < count).
- `err`  output  1  one-cycle pulse: the last accepted count exceeded `N` and was clamped.

## Operation
- **Reset (async, any time):**
  - State → IDLE; beat index, stored count, `out_word`, `out_valid`, `out_bit`, `out_last` and `err` → 0.
  - `in_ready` is held 0 while `rst` is high.
  - A reset mid-stream drops the stream; no further beats are emitted.
- **IDLE:**
  - `in_ready`=1, `out_valid`=0.
  - An input handshake (`in_valid` & `in_ready`) stores cnt = min(`in_count`, `N`), clears the beat index k to 0, loads `out_word`, and moves to SHIFT.
- **SHIFT:**
  - `out_valid`=1, `out_bit` = (k < cnt), `out_last` = (k == `N`-1).
  - Handshake rule: a beat is consumed only when `out_valid` & `out_ready`; then k increments.
  - When `out_ready`=0, all outputs hold stable.
  - Consumption of the last beat: return to IDLE, unless a new input handshake occurs in the same cycle.
- **Back-to-back:** in SHIFT, `in_ready` = `out_last` & `out_ready` (combinational).
  - A handshake on that cycle reloads cnt and `out_word`, resets k=0 and stays in SHIFT.
  - Sustained throughput is one word per `N` cycles.
- **Clamp:** `in_count` values 17..31 are treated as 16 (all ones). `err` pulses high for exactly the cycle after that acceptance.
- **Word output:** `out_word` holds its value from acceptance until the next acceptance; it is not cleared on return to IDLE.
- **Width rules:** comparison k < cnt is unsigned on `CW` bits; k ranges 0..`N`-1 and never wraps inside a stream.

## Timing
- Latency: acceptance at edge t → first beat valid from t+1.
- Minimum stream duration is `N` cycles with `out_ready` held high.
- `in_ready` is combinational from state, `out_ready` and k; no combinational path from `in_valid` or `in_count` to any output.
- All other outputs are registered.
- Every serial beat path has the same register depth, so `out_bit` and `out_last` have equal latency from the stored count.

## Test plan
- **Reset behaviour:** reset, then `in_count`=5 with `in_valid`=1 for one cycle and `out_ready`=1 →
  - beats 1,1,1,1,1 then eleven 0s on cycles t+1..t+16;
  - `out_last` only on beat 15;
  - `out_word`=16'h001F;
  - `in_ready`=1 again at t+17.
- **Range ends:** counts 0 and 16 →
  - 0 gives 16 zeros and `out_word`=16'h0000;
  - 16 gives 16 ones and `out_word`=16'hFFFF;
  - `err` stays 0 for both.
- **Clamp:** `in_count`=23 → stream identical to count 16, `err` pulses exactly one cycle at t+1.
- **Backpressure:** count 9 with `out_ready` toggling 1,0,0,1,…
  - `out_bit` and `out_last` hold while stalled;
  - the sequence is still nine 1s then seven 0s;
  - no beat is lost or duplicated.
- **Back-to-back:** count 3 then count 12, with `in_valid` held high and `out_ready`=1 →
  - second acceptance on the cycle of the first stream's `out_last`;
  - 32 contiguous beats (3 ones, 13 zeros, 12 ones, 4 zeros);
  - `out_valid` never drops.
- **Reset mid-stream:** assert `rst` at beat 7 of count 10 →
  - `out_valid`, `out_bit`, `out_word` → 0 immediately;
  - after release, `in_ready`=1 and a new count 2 streams correctly from beat 0.
